// File: rtl/dram_axi_bridge_pkg.sv
// Shared types and constants for the DRAM-channel to SRAM bridge.
package dram_axi_bridge_pkg;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned IDX_W  = 8;
  localparam int unsigned DLY_W  = 4;

  localparam logic [ADDR_W-1:0] BRIDGE_BASE_ADDR = 17'h10000;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_t;

  typedef enum logic [3:0] {
    IDLE,
    RD_DLY,
    RD_MEM,
    RD_CAP,
    RD_RESP,
    WR_W,
    WR_DLY,
    WR_MEM,
    WR_RESP
  } bridge_state_t;

endpackage

// File: rtl/dram_axi_bridge_addr_decode.sv
// Byte address to SRAM record index, flagging misaligned or out-of-window addresses.
module dram_axi_bridge_addr_decode
  import dram_axi_bridge_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE  = BRIDGE_BASE_ADDR,
  parameter int unsigned       DEPTH = 256
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              err_o
);

  logic [ADDR_W-1:0] offs;
  logic [ADDR_W-1:0] rec_idx;

  // Full 17-bit record number is kept so indices past DEPTH are caught.
  always_comb begin
    offs    = addr_i - BASE;
    rec_idx = offs >> 3;
    idx_o   = rec_idx[IDX_W-1:0];
    err_o   = (addr_i[2:0] != 3'd0) || (addr_i < BASE) || (rec_idx >= ADDR_W'(DEPTH));
  end

endmodule

// File: rtl/dram_axi_bridge.sv
// AXI4-lite-style slave turning DRAM-channel transactions into delayed single-word SRAM accesses.
module dram_axi_bridge
  import dram_axi_bridge_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = BRIDGE_BASE_ADDR,
  parameter int unsigned       DEPTH     = 256,
  parameter int unsigned       RESP_DLY  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              AR_VALID,
  input  logic [ADDR_W-1:0] AR_ADDR,
  output logic              AR_READY,
  output logic              R_VALID,
  output logic [DATA_W-1:0] R_DATA,
  output logic [1:0]        R_RESP,
  input  logic              R_READY,
  input  logic              AW_VALID,
  input  logic [ADDR_W-1:0] AW_ADDR,
  output logic              AW_READY,
  input  logic              W_VALID,
  input  logic [DATA_W-1:0] W_DATA,
  output logic              W_READY,
  output logic              B_VALID,
  output logic [1:0]        B_RESP,
  input  logic              B_READY,
  output logic              mem_en,
  output logic              mem_we,
  output logic [IDX_W-1:0]  mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam bit                 NO_DLY   = (RESP_DLY == 0);
  localparam logic [DLY_W-1:0]   DLY_LAST = DLY_W'(RESP_DLY - 1);

  bridge_state_t     state_q;
  logic [DLY_W-1:0]  cnt_q;
  logic              aw_pend_q;
  logic              rdy_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              r_valid_q;
  logic [DATA_W-1:0] r_data_q;
  axi_resp_t         r_resp_q;
  logic              b_valid_q;
  axi_resp_t         b_resp_q;

  logic              in_rd;
  logic [ADDR_W-1:0] cur_addr;
  logic [IDX_W-1:0]  cur_idx;
  logic              cur_err;

  assign in_rd    = (state_q == RD_DLY) || (state_q == RD_MEM) ||
                    (state_q == RD_CAP) || (state_q == RD_RESP);
  assign cur_addr = in_rd ? rd_addr_q : wr_addr_q;

  dram_axi_bridge_addr_decode #(
    .BASE  (BASE_ADDR),
    .DEPTH (DEPTH)
  ) u_addr_decode (
    .addr_i (cur_addr),
    .idx_o  (cur_idx),
    .err_o  (cur_err)
  );

  // Memory strobes decode from state so a reset can never leave a write half-issued.
  assign AR_READY  = rdy_q;
  assign AW_READY  = rdy_q;
  assign W_READY   = (state_q == WR_W);
  assign R_VALID   = r_valid_q;
  assign R_DATA    = r_data_q;
  assign R_RESP    = r_resp_q;
  assign B_VALID   = b_valid_q;
  assign B_RESP    = b_resp_q;
  assign mem_en    = ((state_q == RD_MEM) || (state_q == WR_MEM)) && !cur_err;
  assign mem_we    = (state_q == WR_MEM) && !cur_err;
  assign mem_addr  = cur_idx;
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      aw_pend_q <= 1'b0;
      rdy_q     <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wdata_q   <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
      b_valid_q <= 1'b0;
      b_resp_q  <= RESP_OKAY;
    end else begin
      case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          // AR wins; a simultaneous AW is parked so it is not lost when AW_VALID drops.
          if (rdy_q && AR_VALID) begin
            rdy_q     <= 1'b0;
            rd_addr_q <= AR_ADDR;
            state_q   <= NO_DLY ? RD_MEM : RD_DLY;
            if (AW_VALID) begin
              wr_addr_q <= AW_ADDR;
              aw_pend_q <= 1'b1;
            end
          end else if (rdy_q && AW_VALID) begin
            rdy_q     <= 1'b0;
            wr_addr_q <= AW_ADDR;
            state_q   <= WR_W;
          end
        end
        RD_DLY: begin
          if (cnt_q == DLY_LAST) begin
            cnt_q   <= '0;
            state_q <= RD_MEM;
          end else begin
            cnt_q <= cnt_q + DLY_W'(1);
          end
        end
        RD_MEM: state_q <= RD_CAP;
        RD_CAP: begin
          r_data_q <= cur_err ? '0 : mem_rdata;
          r_resp_q <= cur_err ? RESP_SLVERR : RESP_OKAY;
          state_q  <= RD_RESP;
        end
        RD_RESP: begin
          if (!r_valid_q) begin
            r_valid_q <= 1'b1;
          end else if (R_READY) begin
            r_valid_q <= 1'b0;
            if (aw_pend_q) begin
              state_q <= WR_W;
            end else begin
              state_q <= IDLE;
              rdy_q   <= 1'b1;
            end
          end
        end
        WR_W: begin
          if (W_VALID) begin
            wdata_q   <= W_DATA;
            aw_pend_q <= 1'b0;
            state_q   <= NO_DLY ? WR_MEM : WR_DLY;
          end
        end
        WR_DLY: begin
          if (cnt_q == DLY_LAST) begin
            cnt_q   <= '0;
            state_q <= WR_MEM;
          end else begin
            cnt_q <= cnt_q + DLY_W'(1);
          end
        end
        WR_MEM: begin
          b_resp_q <= cur_err ? RESP_SLVERR : RESP_OKAY;
          state_q  <= WR_RESP;
        end
        WR_RESP: begin
          if (!b_valid_q) begin
            b_valid_q <= 1'b1;
          end else if (B_READY) begin
            b_valid_q <= 1'b0;
            state_q   <= IDLE;
            rdy_q     <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_axi_bridge.sv
// Scoreboard bench: a record-array model predicts responses, a monitor checks them as they appear.
module tb_dram_axi_bridge;

  localparam int BASE   = 'h10000;
  localparam int DEPTH  = 256;
  localparam int RD_LAT = 7;
  localparam int WR_LAT = 6;
  localparam int BOUND  = 300;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        AR_VALID, AR_READY, R_VALID, R_READY, AW_VALID, AW_READY;
  logic        W_VALID, W_READY, B_VALID, B_READY, mem_en, mem_we;
  logic [16:0] AR_ADDR, AW_ADDR;
  logic [63:0] R_DATA, W_DATA, mem_wdata, mem_rdata;
  logic [1:0]  R_RESP, B_RESP;
  logic [7:0]  mem_addr;

  logic        z_ar_valid, z_ar_ready, z_r_valid, z_r_ready, z_aw_valid, z_aw_ready;
  logic        z_w_valid, z_w_ready, z_b_valid, z_b_ready, z_mem_en, z_mem_we;
  logic [16:0] z_ar_addr, z_aw_addr;
  logic [63:0] z_r_data, z_w_data, z_mem_wdata, z_mem_rdata;
  logic [1:0]  z_r_resp, z_b_resp;
  logic [7:0]  z_mem_addr;

  dram_axi_bridge #(.RESP_DLY(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
    .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
    .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
    .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dram_axi_bridge #(.RESP_DLY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .AR_VALID(z_ar_valid), .AR_ADDR(z_ar_addr), .AR_READY(z_ar_ready),
    .R_VALID(z_r_valid), .R_DATA(z_r_data), .R_RESP(z_r_resp), .R_READY(z_r_ready),
    .AW_VALID(z_aw_valid), .AW_ADDR(z_aw_addr), .AW_READY(z_aw_ready),
    .W_VALID(z_w_valid), .W_DATA(z_w_data), .W_READY(z_w_ready),
    .B_VALID(z_b_valid), .B_RESP(z_b_resp), .B_READY(z_b_ready),
    .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr),
    .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata)
  );

  function automatic logic [63:0] init_word(input int i);
    return (i == 5) ? 64'h0123_4567_89AB_CDEF : {32'hA5A5_0000 + 32'(i), 32'(i * 7 + 1)};
  endfunction

  // Behavioural SRAMs, loaded on their first clock (reset is held then)
  logic [63:0] sram   [DEPTH];
  logic [63:0] z_sram [DEPTH];
  bit sram_ready = 1'b0;
  bit z_sram_ready = 1'b0;
  always @(posedge clk) begin
    if (!sram_ready) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= init_word(i);
      sram_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end
  always @(posedge clk) begin
    if (!z_sram_ready) begin
      for (int i = 0; i < DEPTH; i++) z_sram[i] <= init_word(i);
      z_sram_ready <= 1'b1;
    end else if (z_mem_en) begin
      if (z_mem_we) z_sram[z_mem_addr] <= z_mem_wdata;
      else          z_mem_rdata <= z_sram[z_mem_addr];
    end
  end

  int cyc = 0;
  int mem_en_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_en) mem_en_cnt <= mem_en_cnt + 1;

  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: record array plus address legality rule
  typedef struct packed { logic [63:0] data; logic [1:0] resp; } exp_r_t;
  logic [63:0] ref_mem [DEPTH];
  exp_r_t      rq[$];
  logic [1:0]  wq[$];
  int ar_hs_cyc = 0;
  int w_hs_cyc = 0;

  function automatic bit legal(input logic [16:0] a);
    int ai = int'(a);
    return (ai % 8 == 0) && (ai >= BASE) && (ai < BASE + DEPTH * 8);
  endfunction

  function automatic exp_r_t model_rd(input logic [16:0] a);
    exp_r_t e;
    if (legal(a)) begin e.data = ref_mem[(int'(a) - BASE) / 8]; e.resp = 2'b00; end
    else          begin e.data = 64'h0; e.resp = 2'b10; end
    return e;
  endfunction

  task automatic model_wr(input logic [16:0] a, input logic [63:0] d);
    wq.push_back(legal(a) ? 2'b00 : 2'b10);
    if (legal(a)) ref_mem[(int'(a) - BASE) / 8] = d;
  endtask

  // Monitor: pops the scoreboard when a response is presented, checks hold while it waits
  exp_r_t cur_r;
  logic [1:0] cur_b;
  bit prev_rv = 1'b0;
  bit prev_bv = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (R_VALID && !prev_rv) begin
        if (rq.size() == 0) chk("r_unexpected", 1'b0, R_DATA, 0);
        else begin
          cur_r = rq.pop_front();
          chk("r_data", R_DATA == cur_r.data, R_DATA, cur_r.data);
          chk("r_resp", R_RESP == cur_r.resp, R_RESP, cur_r.resp);
          chk("r_latency", (cyc - ar_hs_cyc) == RD_LAT, cyc - ar_hs_cyc, RD_LAT);
        end
      end else if (R_VALID) begin
        chk("r_hold", R_DATA == cur_r.data && R_RESP == cur_r.resp && !AR_READY, R_DATA, cur_r.data);
      end
      if (B_VALID && !prev_bv) begin
        if (wq.size() == 0) chk("b_unexpected", 1'b0, B_RESP, 0);
        else begin
          cur_b = wq.pop_front();
          chk("b_resp", B_RESP == cur_b, B_RESP, cur_b);
          chk("b_latency", (cyc - w_hs_cyc) == WR_LAT, cyc - w_hs_cyc, WR_LAT);
        end
      end
    end
    prev_rv = R_VALID;
    prev_bv = B_VALID;
  end

  // Response-channel backpressure: 0 always ready, 1 random, 2 stalled
  int rr_mode = 0;
  initial begin
    R_READY = 1'b0;
    B_READY = 1'b0;
    forever begin
      @(posedge clk); #1;
      R_READY = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      B_READY = (rr_mode == 2) ? 1'b1 : (rr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic do_ar(input logic [16:0] a, input bit with_aw);
    int n = 0;
    AR_VALID = 1'b1; AR_ADDR = a;
    if (with_aw) begin AW_VALID = 1'b1; AW_ADDR = a; end
    while (!AR_READY && n < BOUND) begin @(negedge clk); n++; end
    chk("ar_accept", n < BOUND, n, BOUND);
    if (with_aw) chk("aw_ready_same_cycle", AW_READY == 1'b1, AW_READY, 1);
    @(posedge clk); @(negedge clk);
    ar_hs_cyc = cyc;
    AR_VALID = 1'b0; AW_VALID = 1'b0;
  endtask

  task automatic do_aw(input logic [16:0] a);
    int n = 0;
    AW_VALID = 1'b1; AW_ADDR = a;
    while (!AW_READY && n < BOUND) begin @(negedge clk); n++; end
    chk("aw_accept", n < BOUND, n, BOUND);
    @(posedge clk); @(negedge clk);
    AW_VALID = 1'b0;
  endtask

  task automatic do_w(input logic [63:0] d);
    int n = 0;
    W_VALID = 1'b1; W_DATA = d;
    while (!W_READY && n < BOUND) begin @(negedge clk); n++; end
    chk("w_accept", n < BOUND, n, BOUND);
    @(posedge clk); @(negedge clk);
    w_hs_cyc = cyc;
    W_VALID = 1'b0;
  endtask

  task automatic rd(input logic [16:0] a);
    rq.push_back(model_rd(a));
    do_ar(a, 1'b0);
  endtask

  task automatic wr(input logic [16:0] a, input logic [63:0] d);
    model_wr(a, d);
    do_aw(a);
    do_w(d);
  endtask

  task automatic arw(input logic [16:0] a, input logic [63:0] d);
    rq.push_back(model_rd(a));
    do_ar(a, 1'b1);
    model_wr(a, d);
    do_w(d);
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || wq.size() != 0 || R_VALID || B_VALID) && n < BOUND) begin
      @(negedge clk); n++;
    end
    chk("drain", n < BOUND, n, BOUND);
  endtask

  function automatic logic [16:0] rand_addr();
    int r = $urandom_range(0, 9);
    int rec = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(240, 255);
    if (r == 0) return 17'(BASE + 8 * rec + $urandom_range(1, 7));
    if (r == 1) return ($urandom_range(0, 1) == 1) ? 17'(BASE + 8 * DEPTH + 8 * $urandom_range(0, 31))
                                                   : 17'(BASE - 8 * $urandom_range(1, 32));
    return 17'(BASE + 8 * rec);
  endfunction

  function automatic bit outs_zero();
    return !AR_READY && !AW_READY && !W_READY && !R_VALID && !B_VALID && !mem_en && !mem_we &&
           mem_addr == 8'h0 && R_DATA == 64'h0 && R_RESP == 2'b00 && B_RESP == 2'b00 && mem_wdata == 64'h0;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, h, cnt0, bad;
    logic [63:0] d;
    logic [16:0] a;
    AR_VALID = 0; AR_ADDR = '0; AW_VALID = 0; AW_ADDR = '0; W_VALID = 0; W_DATA = '0;
    z_ar_valid = 0; z_ar_addr = '0; z_aw_valid = 0; z_aw_addr = '0; z_w_valid = 0; z_w_data = '0;
    z_r_ready = 1'b1; z_b_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs_zero(), {AR_READY, R_VALID, B_VALID, mem_en}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", AR_READY && AW_READY && !W_READY, {AR_READY, AW_READY, W_READY}, 3'b110);

    rd(17'h10028);
    arw(17'h10010, 64'hFFFF);
    drain();
    rd(17'h10010);
    drain();

    cnt0 = mem_en_cnt;
    rd(17'h1000C);
    rd(17'h10800);
    wr(17'h10804, 64'h1234);
    drain();
    chk("error_no_mem_access", mem_en_cnt == cnt0, mem_en_cnt - cnt0, 0);

    rd(17'h107F8);
    wr(17'h107F8, 64'hBEEF_0000_0000_00FF);
    wr(17'h0FFF8, 64'h5555);
    rd(17'h107F8);
    drain();

    rr_mode = 2;
    rd(17'h10028);
    n = 0;
    while (!R_VALID && n < BOUND) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    chk("r_stall_valid", R_VALID == 1'b1, R_VALID, 1);
    rr_mode = 0;
    drain();

    W_VALID = 1'b1; W_DATA = 64'hABCD_EF01_2345_6789;
    repeat (3) begin
      @(negedge clk);
      chk("w_early_ignored", !W_READY, W_READY, 0);
    end
    wr(17'h10040, 64'hABCD_EF01_2345_6789);
    drain();

    do_aw(17'h10030);
    do_w(64'hDEAD_BEEF_DEAD_BEEF);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_write", outs_zero(), {AR_READY, W_READY, B_VALID, mem_en}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("reset_mem_unchanged", sram[6] == ref_mem[6], sram[6], ref_mem[6]);
    rd(17'h10030);
    drain();

    rr_mode = 1;
    for (int i = 0; i < 40; i++) begin
      a = rand_addr();
      d = {$urandom, $urandom};
      case ($urandom_range(0, 2))
        0: rd(a);
        1: wr(a, d);
        default: arw(a, d);
      endcase
    end
    drain();
    rr_mode = 0;
    drain();

    z_ar_addr = 17'h10018; z_ar_valid = 1'b1;
    n = 0;
    while (!z_ar_ready && n < BOUND) begin @(negedge clk); n++; end
    @(posedge clk); @(negedge clk);
    h = cyc; z_ar_valid = 1'b0;
    n = 0;
    while (!z_r_valid && n < BOUND) begin @(negedge clk); n++; end
    chk("z_rd_latency", (cyc - h) == 3, cyc - h, 3);
    chk("z_rd_data", z_r_data == init_word(3) && z_r_resp == 2'b00, z_r_data, init_word(3));
    @(negedge clk);
    z_aw_addr = 17'h10020; z_aw_valid = 1'b1;
    n = 0;
    while (!z_aw_ready && n < BOUND) begin @(negedge clk); n++; end
    @(posedge clk); @(negedge clk);
    z_aw_valid = 1'b0;
    z_w_data = 64'h7777_0000_1111_2222; z_w_valid = 1'b1;
    n = 0;
    while (!z_w_ready && n < BOUND) begin @(negedge clk); n++; end
    @(posedge clk); @(negedge clk);
    h = cyc; z_w_valid = 1'b0;
    n = 0;
    while (!z_b_valid && n < BOUND) begin @(negedge clk); n++; end
    chk("z_wr_latency", (cyc - h) == 2, cyc - h, 2);
    chk("z_wr_resp", z_b_resp == 2'b00, z_b_resp, 0);
    repeat (2) @(negedge clk);
    chk("z_mem_written", z_sram[4] == 64'h7777_0000_1111_2222, z_sram[4], 64'h7777_0000_1111_2222);

    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (sram[i] !== ref_mem[i]) bad++;
    chk("final_memory", bad == 0, bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
